// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU arbiter: FSM states, ALU command encodings and
// the latched operation record.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    localparam logic [2:0] CMD_LDR    = 3'b000;
    localparam logic [2:0] CMD_STR    = 3'b001;
    localparam logic [2:0] CMD_MOVADD = 3'b010;
    localparam logic [2:0] CMD_XOR    = 3'b011;
    localparam logic [2:0] CMD_AND    = 3'b100;
    localparam logic [2:0] CMD_SHIFT  = 3'b101;
    localparam logic [2:0] CMD_CMP    = 3'b110;
    localparam logic [2:0] CMD_BR     = 3'b111;

    typedef struct packed {
        logic [2:0] cmd;
        logic [1:0] immed;
        logic       direct;
        logic       move;
        logic [7:0] a;
        logic [7:0] b;
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 8-bit ALU shared by both requesters of alu_arbiter.
// All arithmetic wraps modulo 256.
module alu
    import alu_ctrl_pkg::*;
(
    input  logic [2:0] cmd,
    input  logic [1:0] immed,
    input  logic       direct,
    input  logic       move,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] rslt,
    output logic       br_logic
);

    always_comb begin
        rslt     = 8'h00;
        br_logic = 1'b0;
        case (cmd)
            CMD_LDR, CMD_STR: rslt = b;
            CMD_MOVADD:       rslt = move ? (a + {6'b0, immed}) : {6'b0, immed};
            CMD_XOR:          rslt = a ^ b;
            CMD_AND:          rslt = a & b;
            CMD_SHIFT:        rslt = direct ? (a >> immed) : (a << immed);
            CMD_CMP:          br_logic = (a == b);
            CMD_BR:           rslt = 8'h00;
            default:          rslt = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU: accept one operation,
// execute it from registers, then hold the result until its owner takes it.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_cmd,
    input  logic [1:0] req0_immed,
    input  logic       req0_direct,
    input  logic       req0_move,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_rslt,
    output logic       rsp0_br,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_cmd,
    input  logic [1:0] req1_immed,
    input  logic       req1_direct,
    input  logic       req1_move,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_rslt,
    output logic       rsp1_br
);

    arb_state_t state, next_state;
    alu_op_t    op_q;
    alu_op_t    req0_op, req1_op;
    logic       owner, last_grant;
    logic       winner, any_valid, handshake;
    logic [7:0] rslt_q, alu_rslt;
    logic       br_q, alu_br;

    assign req0_op = {req0_cmd, req0_immed, req0_direct, req0_move, req0_a, req0_b};
    assign req1_op = {req1_cmd, req1_immed, req1_direct, req1_move, req1_a, req1_b};

    // On a tie, round-robin hands the grant to whoever did not win last time.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        winner    = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = FAIR ? ~last_grant : 1'b0;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    assign handshake = (state == IDLE) && any_valid;

    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req0_ready = ~winner;
                    req1_ready = winner;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if ((~owner & rsp0_ready) | (owner & rsp1_ready)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Result lines read as zero whenever the response channel is not valid.
    assign rsp0_rslt = rsp0_valid ? rslt_q : 8'h00;
    assign rsp0_br   = rsp0_valid & br_q;
    assign rsp1_rslt = rsp1_valid ? rslt_q : 8'h00;
    assign rsp1_br   = rsp1_valid & br_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_q       <= '0;
            rslt_q     <= 8'h00;
            br_q       <= 1'b0;
        end else begin
            state <= next_state;
            if (handshake) begin
                owner      <= winner;
                last_grant <= winner;
                op_q       <= winner ? req1_op : req0_op;
            end
            if (state == EXEC) begin
                rslt_q <= alu_rslt;
                br_q   <= alu_br;
            end
        end
    end

    alu u_alu (
        .cmd      (op_q.cmd),
        .immed    (op_q.immed),
        .direct   (op_q.direct),
        .move     (op_q.move),
        .a        (op_q.a),
        .b        (op_q.b),
        .rslt     (alu_rslt),
        .br_logic (alu_br)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; expected values are hand-computed.
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       req_valid  [2];
    logic [2:0] req_cmd    [2];
    logic [1:0] req_immed  [2];
    logic       req_direct [2];
    logic       req_move   [2];
    logic [7:0] req_a      [2];
    logic [7:0] req_b      [2];
    logic       rsp_ready  [2];

    logic       req_ready  [2];
    logic       rsp_valid  [2];
    logic [7:0] rsp_rslt   [2];
    logic       rsp_br     [2];

    logic       fp_req_ready [2];
    logic       fp_rsp_valid [2];
    logic [7:0] fp_rsp_rslt  [2];
    logic       fp_rsp_br    [2];

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_cmd(req_cmd[0]),
        .req0_immed(req_immed[0]), .req0_direct(req_direct[0]), .req0_move(req_move[0]),
        .req0_a(req_a[0]), .req0_b(req_b[0]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_rslt(rsp_rslt[0]), .rsp0_br(rsp_br[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_cmd(req_cmd[1]),
        .req1_immed(req_immed[1]), .req1_direct(req_direct[1]), .req1_move(req_move[1]),
        .req1_a(req_a[1]), .req1_b(req_b[1]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_rslt(rsp_rslt[1]), .rsp1_br(rsp_br[1])
    );

    alu_arbiter #(.FAIR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0]), .req0_ready(fp_req_ready[0]), .req0_cmd(req_cmd[0]),
        .req0_immed(req_immed[0]), .req0_direct(req_direct[0]), .req0_move(req_move[0]),
        .req0_a(req_a[0]), .req0_b(req_b[0]),
        .rsp0_valid(fp_rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_rslt(fp_rsp_rslt[0]), .rsp0_br(fp_rsp_br[0]),
        .req1_valid(req_valid[1]), .req1_ready(fp_req_ready[1]), .req1_cmd(req_cmd[1]),
        .req1_immed(req_immed[1]), .req1_direct(req_direct[1]), .req1_move(req_move[1]),
        .req1_a(req_a[1]), .req1_b(req_b[1]),
        .rsp1_valid(fp_rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_rslt(fp_rsp_rslt[1]), .rsp1_br(fp_rsp_br[1])
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [2:0] cmd, input logic [1:0] immed,
                                 input logic direct, input logic move,
                                 input logic [7:0] a, input logic [7:0] b);
        req_cmd[n]    = cmd;
        req_immed[n]  = immed;
        req_direct[n] = direct;
        req_move[n]   = move;
        req_a[n]      = a;
        req_b[n]      = b;
        req_valid[n]  = 1'b1;
    endtask

    task automatic resetDut();
        rst_n        = 1'b0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full transaction on requester n, starting and ending at a falling edge.
    task automatic doOp(input int n, input logic [2:0] cmd, input logic [1:0] immed,
                        input logic direct, input logic move,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] expRslt, input logic expBr, input string tag);
        bit seen;
        seen = 1'b0;
        applyStimulus(n, cmd, immed, direct, move, a, b);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[n]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_grant"}, 32'(seen), 32'd1);
        if (!seen) begin
            req_valid[n] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[n] = 1'b0;
        #1;
        checkOutput({tag, "_exec_ready"}, 32'(req_ready[n]), 32'd0);
        checkOutput({tag, "_exec_valid"}, 32'(rsp_valid[n]), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, "_valid"}, 32'(rsp_valid[n]), 32'd1);
        checkOutput({tag, "_other_valid"}, 32'(rsp_valid[1-n]), 32'd0);
        checkOutput({tag, "_rslt"}, 32'(rsp_rslt[n]), 32'(expRslt));
        checkOutput({tag, "_br"}, 32'(rsp_br[n]), 32'(expBr));
        @(negedge clk);
    endtask

    initial begin
        int grants;
        int rsps;
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_cmd[i] = 3'b0; req_immed[i] = 2'b0;
            req_direct[i] = 1'b0; req_move[i] = 1'b0; req_a[i] = 8'h00; req_b[i] = 8'h00;
            rsp_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_req_ready", 32'(req_ready[i]), 32'd0);
            checkOutput("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            checkOutput("reset_rsp_rslt", 32'(rsp_rslt[i]), 32'd0);
            checkOutput("reset_rsp_br", 32'(rsp_br[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single requester ADD");
        doOp(0, CMD_MOVADD, 2'd2, 1'b0, 1'b1, 8'h05, 8'h00, 8'h07, 1'b0, "add");

        $display("[TB] tie after reset");
        resetDut();
        applyStimulus(0, CMD_XOR, 2'd0, 1'b0, 1'b0, 8'hF0, 8'hFF);
        applyStimulus(1, CMD_AND, 2'd0, 1'b0, 1'b0, 8'h3C, 8'h0F);
        #1;
        checkOutput("tie_r0_ready", 32'(req_ready[0]), 32'd1);
        checkOutput("tie_r1_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        checkOutput("tie_exec_r1_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("tie_rsp0_valid", 32'(rsp_valid[0]), 32'd1);
        checkOutput("tie_rsp0_rslt", 32'(rsp_rslt[0]), 32'h0F);
        checkOutput("tie_rsp1_valid", 32'(rsp_valid[1]), 32'd0);
        checkOutput("tie_resp_r1_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("tie_cycle3_r1_ready", 32'(req_ready[1]), 32'd1);
        doOp(1, CMD_AND, 2'd0, 1'b0, 1'b0, 8'h3C, 8'h0F, 8'h0C, 1'b0, "tie_and");

        $display("[TB] backpressure");
        rsp_ready[1] = 1'b0;
        applyStimulus(1, CMD_SHIFT, 2'd3, 1'b1, 1'b0, 8'h80, 8'h00);
        #1;
        checkOutput("bp_r1_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        applyStimulus(0, CMD_AND, 2'd0, 1'b0, 1'b0, 8'hFF, 8'hAA);
        #1;
        checkOutput("bp_exec_r0_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_valid", 32'(rsp_valid[1]), 32'd1);
            checkOutput("bp_rslt", 32'(rsp_rslt[1]), 32'h10);
            checkOutput("bp_br", 32'(rsp_br[1]), 32'd0);
            checkOutput("bp_r0_ready", 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        #1;
        checkOutput("bp_release_valid", 32'(rsp_valid[1]), 32'd1);
        checkOutput("bp_release_r0_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("bp_after_r0_ready", 32'(req_ready[0]), 32'd1);
        doOp(0, CMD_AND, 2'd0, 1'b0, 1'b0, 8'hFF, 8'hAA, 8'hAA, 1'b0, "bp_and");

        $display("[TB] directed ALU vectors");
        doOp(0, CMD_CMP,    2'd0, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h00, 1'b1, "cmp_eq");
        doOp(1, CMD_CMP,    2'd0, 1'b0, 1'b0, 8'h5A, 8'h5B, 8'h00, 1'b0, "cmp_ne");
        doOp(0, CMD_MOVADD, 2'd1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, "add_wrap");
        doOp(1, CMD_MOVADD, 2'd3, 1'b0, 1'b0, 8'h40, 8'h00, 8'h03, 1'b0, "mov");
        doOp(0, CMD_LDR,    2'd0, 1'b0, 1'b0, 8'h11, 8'hC3, 8'hC3, 1'b0, "ldr");
        doOp(1, CMD_STR,    2'd0, 1'b0, 1'b0, 8'h22, 8'h3C, 8'h3C, 1'b0, "str");
        doOp(0, CMD_SHIFT,  2'd1, 1'b0, 1'b0, 8'h81, 8'h00, 8'h02, 1'b0, "shl");
        doOp(1, CMD_BR,     2'd0, 1'b0, 1'b0, 8'h12, 8'h12, 8'h00, 1'b0, "br");

        $display("[TB] reset during EXEC");
        applyStimulus(0, CMD_MOVADD, 2'd1, 1'b0, 1'b1, 8'h10, 8'h00);
        #1;
        checkOutput("rx_grant", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("rx_no_rsp0", 32'(rsp_valid[0]), 32'd0);
            checkOutput("rx_no_rsp1", 32'(rsp_valid[1]), 32'd0);
            @(negedge clk);
        end
        applyStimulus(0, CMD_XOR, 2'd0, 1'b0, 1'b0, 8'h55, 8'hAA);
        applyStimulus(1, CMD_AND, 2'd0, 1'b0, 1'b0, 8'h55, 8'hAA);
        #1;
        checkOutput("rx_tie_r0_ready", 32'(req_ready[0]), 32'd1);
        checkOutput("rx_tie_r1_ready", 32'(req_ready[1]), 32'd0);
        req_valid[1] = 1'b0;
        doOp(0, CMD_XOR, 2'd0, 1'b0, 1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, "rx_xor");

        $display("[TB] fixed priority");
        resetDut();
        applyStimulus(0, CMD_MOVADD, 2'd1, 1'b0, 1'b1, 8'h20, 8'h00);
        applyStimulus(1, CMD_AND, 2'd0, 1'b0, 1'b0, 8'hF0, 8'h0F);
        grants = 0;
        rsps   = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            checkOutput("fp_r1_ready", 32'(fp_req_ready[1]), 32'd0);
            checkOutput("fp_rsp1_valid", 32'(fp_rsp_valid[1]), 32'd0);
            if (fp_req_ready[0]) grants++;
            if (fp_rsp_valid[0]) begin
                rsps++;
                checkOutput("fp_rslt", 32'(fp_rsp_rslt[0]), 32'h21);
            end
            @(negedge clk);
        end
        checkOutput("fp_grants", 32'(grants), 32'd10);
        checkOutput("fp_rsps", 32'(rsps), 32'd10);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
